// File: rtl/bp_fe_pkg.sv
// Shared front-end types: BTB entry type encoding and the branch metadata
// checkpoint that travels from lookup to resolution and back.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_btb_branch = 2'd0,
    e_btb_jump   = 2'd1,
    e_btb_call   = 2'd2,
    e_btb_return = 2'd3
  } bp_fe_btb_type_e;

endpackage

`ifndef BP_FE_BRANCH_METADATA_FWD_S
`define BP_FE_BRANCH_METADATA_FWD_S
// Checkpoint layout, MSB first: {btb_indx, bht_indx, ras_ptr, ghist}.
`define DECLARE_BP_FE_BRANCH_METADATA_FWD_S(btb_indx_width_mp, bht_indx_width_mp, ras_ptr_width_mp, ghist_width_mp) \
  typedef struct packed { \
    logic [btb_indx_width_mp-1:0] btb_indx; \
    logic [bht_indx_width_mp-1:0] bht_indx; \
    logic [ras_ptr_width_mp-1:0]  ras_ptr; \
    logic [ghist_width_mp-1:0]    ghist; \
  } bp_fe_branch_metadata_fwd_s
`endif

// File: rtl/bp_fe_ras.sv
// Circular return-address stack. Overflow overwrites the oldest entry and
// underflow simply reads whatever stale address is below the pointer.
module bp_fe_ras
  import bp_fe_pkg::*;
#(
  parameter int eaddr_width_p = 39,
  parameter int ras_depth_p   = 8,
  localparam int ptr_width_lp = $clog2(ras_depth_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [eaddr_width_p-1:0] push_addr_i,
  input  logic                     pop_i,
  input  logic                     restore_i,
  input  logic [ptr_width_lp-1:0]  restore_ptr_i,
  output logic [ptr_width_lp-1:0]  ptr_o,
  output logic [eaddr_width_p-1:0] top_o
);

  logic [eaddr_width_p-1:0] mem [ras_depth_p];
  logic [ptr_width_lp-1:0]  ptr;

  // Pointer: a checkpoint restore overrides any speculative push or pop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr <= '0;
    end else if (restore_i) begin
      ptr <= restore_ptr_i;
    end else if (push_i) begin
      ptr <= ptr + ptr_width_lp'(1);
    end else if (pop_i) begin
      ptr <= ptr - ptr_width_lp'(1);
    end
  end

  // Storage: a push writes at the current pointer; squashed when restoring.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < ras_depth_p; i++) mem[i] <= '0;
    end else if (push_i && !restore_i) begin
      mem[ptr] <= push_addr_i;
    end
  end

  assign ptr_o = ptr;
  assign top_o = mem[ptr - ptr_width_lp'(1)];

endmodule

// File: rtl/bp_fe_bp_gshare.sv
// Gshare branch predictor: tagged typed BTB, 2-bit counter BHT indexed by
// PC ^ speculative global history, and a circular RAS. One-cycle lookup;
// resolution updates carry the lookup checkpoint for repair on mispredict.
module bp_fe_bp_gshare
  import bp_fe_pkg::*;
#(
  parameter int eaddr_width_p    = 39,
  parameter int btb_indx_width_p = 6,
  parameter int btb_tag_width_p  = 10,
  parameter int bht_indx_width_p = 9,
  parameter int ghist_width_p    = 8,
  parameter int ras_depth_p      = 8,
  localparam int ras_ptr_width_lp  = $clog2(ras_depth_p),
  localparam int metadata_width_lp = btb_indx_width_p + bht_indx_width_p
                                   + ras_ptr_width_lp + ghist_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         r_v_i,
  input  logic [eaddr_width_p-1:0]     pc_i,
  output logic                         predict_v_o,
  output logic                         taken_o,
  output logic [eaddr_width_p-1:0]     target_o,
  output logic [metadata_width_lp-1:0] metadata_o,
  input  logic                         upd_v_i,
  input  logic [metadata_width_lp-1:0] upd_metadata_i,
  input  logic [eaddr_width_p-1:0]     upd_pc_i,
  input  logic [1:0]                   upd_type_i,
  input  logic                         upd_taken_i,
  input  logic [eaddr_width_p-1:0]     upd_target_i,
  input  logic                         upd_mispredict_i
);

  `DECLARE_BP_FE_BRANCH_METADATA_FWD_S(btb_indx_width_p, bht_indx_width_p, ras_ptr_width_lp, ghist_width_p);

  localparam int btb_els_lp = 2 ** btb_indx_width_p;
  localparam int bht_els_lp = 2 ** bht_indx_width_p;
  localparam int tag_lsb_lp = btb_indx_width_p + 2;
  localparam int tag_msb_lp = btb_indx_width_p + btb_tag_width_p + 1;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
    if (up) sat_ctr = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    sat_ctr = (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  function automatic logic [ghist_width_p-1:0] shift_ghist(input logic [ghist_width_p-1:0] g,
                                                          input logic b);
    shift_ghist = (g << 1) | ghist_width_p'(b);
  endfunction

  // Prediction tables
  logic                       btb_valid  [btb_els_lp];
  logic [btb_tag_width_p-1:0] btb_tag    [btb_els_lp];
  bp_fe_btb_type_e            btb_type   [btb_els_lp];
  logic [eaddr_width_p-1:0]   btb_target [btb_els_lp];
  logic [1:0]                 bht        [bht_els_lp];

  logic [ghist_width_p-1:0]    ghist;
  logic [ras_ptr_width_lp-1:0] ras_ptr;
  logic [eaddr_width_p-1:0]    ras_top;

  logic [btb_indx_width_p-1:0] btb_indx;
  logic [btb_tag_width_p-1:0]  tag;
  logic [btb_tag_width_p-1:0]  upd_tag;
  logic [bht_indx_width_p-1:0] bht_indx;
  logic                        hit;
  logic                        taken_c;
  bp_fe_btb_type_e             type_c;
  logic [eaddr_width_p-1:0]    target_c;
  bp_fe_branch_metadata_fwd_s  meta_c;
  bp_fe_branch_metadata_fwd_s  upd_meta;
  bp_fe_btb_type_e             upd_type;
  logic                        restore;
  logic [ras_ptr_width_lp-1:0] ras_restore_ptr;

  logic                        vld_p0;
  logic                        taken_p0;
  logic [eaddr_width_p-1:0]    target_p0;
  bp_fe_branch_metadata_fwd_s  meta_p0;
  bp_fe_btb_type_e             type_p0;
  logic [eaddr_width_p-1:0]    pc_p0;

  logic unused_bits;
  assign unused_bits = ^{pc_i, upd_pc_i};

  assign btb_indx = pc_i[btb_indx_width_p+1:2];
  assign tag      = pc_i[tag_msb_lp:tag_lsb_lp];
  assign upd_tag  = upd_pc_i[tag_msb_lp:tag_lsb_lp];
  assign bht_indx = pc_i[bht_indx_width_p+1:2] ^ bht_indx_width_p'(ghist);

  assign type_c   = btb_type[btb_indx];
  assign hit      = btb_valid[btb_indx] && (btb_tag[btb_indx] == tag);
  assign taken_c  = (type_c != e_btb_branch) || bht[bht_indx][1];
  assign target_c = (type_c == e_btb_return) ? ras_top : btb_target[btb_indx];
  assign meta_c   = {btb_indx, bht_indx, ras_ptr, ghist};

  assign upd_meta = upd_metadata_i;
  assign upd_type = bp_fe_btb_type_e'(upd_type_i);
  assign restore  = upd_v_i && upd_mispredict_i;

  // Stage 0: registered prediction; a same-cycle restore squashes it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p0    <= 1'b0;
      taken_p0  <= 1'b0;
      target_p0 <= '0;
      meta_p0   <= '0;
      type_p0   <= e_btb_branch;
      pc_p0     <= '0;
    end else begin
      vld_p0   <= r_v_i && hit && !restore;
      taken_p0 <= r_v_i && hit && taken_c && !restore;
      if (r_v_i) begin
        target_p0 <= target_c;
        meta_p0   <= meta_c;
        type_p0   <= type_c;
        pc_p0     <= pc_i;
      end
    end
  end

  // Stage 1: speculative history shift for the prediction now on the outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ghist <= '0;
    end else if (restore) begin
      ghist <= (upd_type == e_btb_branch) ? shift_ghist(upd_meta.ghist, upd_taken_i)
                                          : upd_meta.ghist;
    end else if (vld_p0 && type_p0 == e_btb_branch) begin
      ghist <= shift_ghist(ghist, taken_p0);
    end
  end

  // Repaired RAS pointer re-applies the resolved call/return itself.
  always_comb begin
    ras_restore_ptr = upd_meta.ras_ptr;
    if (upd_type == e_btb_call)        ras_restore_ptr = upd_meta.ras_ptr + ras_ptr_width_lp'(1);
    else if (upd_type == e_btb_return) ras_restore_ptr = upd_meta.ras_ptr - ras_ptr_width_lp'(1);
  end

  bp_fe_ras #(
    .eaddr_width_p (eaddr_width_p),
    .ras_depth_p   (ras_depth_p)
  ) ras (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .push_i        (vld_p0 && type_p0 == e_btb_call),
    .push_addr_i   (pc_p0 + eaddr_width_p'(4)),
    .pop_i         (vld_p0 && type_p0 == e_btb_return),
    .restore_i     (restore),
    .restore_ptr_i (ras_restore_ptr),
    .ptr_o         (ras_ptr),
    .top_o         (ras_top)
  );

  // BTB valid bits: cleared on reset, set by every resolution update.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < btb_els_lp; i++) btb_valid[i] <= 1'b0;
    end else if (upd_v_i) begin
      btb_valid[upd_meta.btb_indx] <= 1'b1;
    end
  end

  // BTB payload: tag, type and target written alongside the valid bit.
  always_ff @(posedge clk_i) begin
    if (upd_v_i) begin
      btb_tag[upd_meta.btb_indx]    <= upd_tag;
      btb_type[upd_meta.btb_indx]   <= upd_type;
      btb_target[upd_meta.btb_indx] <= upd_target_i;
    end
  end

  // BHT: counters start weakly not-taken and train on resolved branches only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < bht_els_lp; i++) bht[i] <= 2'b01;
    end else if (upd_v_i && upd_type == e_btb_branch) begin
      bht[upd_meta.bht_indx] <= sat_ctr(bht[upd_meta.bht_indx], upd_taken_i);
    end
  end

  assign predict_v_o = vld_p0;
  assign taken_o     = taken_p0;
  assign target_o    = target_p0;
  assign metadata_o  = meta_p0;

endmodule

// File: tb/tb_bp_fe_bp_gshare.sv
// Self-checking bench for bp_fe_bp_gshare: directed scenarios plus a random
// stream, all checked against a behavioural model of the predictor rules.
module tb_bp_fe_bp_gshare;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        r_v = 1'b0;
  logic [38:0] pc_in = '0;
  logic        predict_v, taken;
  logic [38:0] target;
  logic [25:0] metadata;
  logic        upd_v = 1'b0;
  logic [25:0] upd_meta = '0;
  logic [38:0] upd_pc = '0;
  logic [1:0]  upd_type = '0;
  logic        upd_taken = 1'b0;
  logic [38:0] upd_target = '0;
  logic        upd_mis = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_fe_bp_gshare dut (
    .clk_i(clk), .reset_n_i(reset_n), .r_v_i(r_v), .pc_i(pc_in),
    .predict_v_o(predict_v), .taken_o(taken), .target_o(target), .metadata_o(metadata),
    .upd_v_i(upd_v), .upd_metadata_i(upd_meta), .upd_pc_i(upd_pc), .upd_type_i(upd_type),
    .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispredict_i(upd_mis)
  );

  // Behavioural model state
  bit          m_valid [64];
  logic [9:0]  m_tag [64];
  int          m_type [64];
  logic [38:0] m_target [64];
  int          m_ctr [512];
  logic [7:0]  m_gh;
  logic [2:0]  m_rp;
  logic [38:0] m_ras [8];
  // Expected outputs for the prediction currently visible
  logic        e_pv, e_taken, e_rv;
  logic [38:0] e_target, e_pc;
  logic [25:0] e_meta;
  int          e_type;

  function automatic logic [25:0] mk_meta(input logic [5:0] b, input logic [8:0] h,
                                          input logic [2:0] r, input logic [7:0] g);
    return {b, h, r, g};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_type[i] = 0; m_target[i] = '0;
    end
    for (int i = 0; i < 512; i++) m_ctr[i] = 1;
    for (int i = 0; i < 8; i++) m_ras[i] = '0;
    m_gh = '0; m_rp = '0;
    e_pv = 0; e_taken = 0; e_rv = 0; e_target = '0; e_pc = '0; e_meta = '0; e_type = 0;
  endtask

  // One clock: predict from the pre-edge model state, apply update/spec
  // effects at the edge, then expose the prediction and clear inputs.
  task automatic tick();
    logic [5:0] bi, ub;
    logic [9:0] tg;
    logic [8:0] hi, uh;
    logic [7:0] g;
    logic hit, n_pv, n_taken, restore;
    logic [38:0] n_target;
    logic [25:0] n_meta;
    int n_type;
    bi = pc_in[7:2];
    tg = pc_in[17:8];
    hi = pc_in[10:2] ^ {1'b0, m_gh};
    hit = m_valid[bi] && (m_tag[bi] == tg);
    n_type = m_type[bi];
    n_pv = r_v && hit;
    n_taken = n_pv && ((n_type != 0) || (m_ctr[hi] >= 2));
    n_target = (n_type == 3) ? m_ras[m_rp - 3'd1] : m_target[bi];
    n_meta = {bi, hi, m_rp, m_gh};
    restore = upd_v && upd_mis;
    if (upd_v) begin
      ub = upd_meta[25:20];
      m_valid[ub] = 1; m_tag[ub] = upd_pc[17:8]; m_type[ub] = upd_type; m_target[ub] = upd_target;
      if (upd_type == 2'd0) begin
        uh = upd_meta[19:11];
        if (upd_taken) m_ctr[uh] = (m_ctr[uh] == 3) ? 3 : m_ctr[uh] + 1;
        else           m_ctr[uh] = (m_ctr[uh] == 0) ? 0 : m_ctr[uh] - 1;
      end
    end
    if (restore) begin
      g = upd_meta[7:0];
      m_gh = (upd_type == 2'd0) ? {g[6:0], upd_taken} : g;
      m_rp = upd_meta[10:8] + ((upd_type == 2'd2) ? 3'd1 : (upd_type == 2'd3) ? 3'd7 : 3'd0);
    end else if (e_pv) begin
      if (e_type == 0) m_gh = {m_gh[6:0], e_taken};
      else if (e_type == 2) begin m_ras[m_rp] = e_pc + 39'd4; m_rp = m_rp + 3'd1; end
      else if (e_type == 3) m_rp = m_rp - 3'd1;
    end
    if (restore) begin n_pv = 0; n_taken = 0; end
    @(posedge clk); #1;
    e_pv = n_pv; e_taken = n_taken; e_rv = r_v;
    if (r_v) begin e_target = n_target; e_meta = n_meta; e_type = n_type; e_pc = pc_in; end
    r_v = 0; upd_v = 0; upd_mis = 0;
  endtask

  task automatic set_upd(input logic [38:0] p, input logic [1:0] t, input logic tk,
                         input logic [38:0] tgt, input logic mis, input logic [25:0] md);
    upd_v = 1; upd_pc = p; upd_type = t; upd_taken = tk; upd_target = tgt;
    upd_mis = mis; upd_meta = md;
  endtask

  task automatic test_reset();
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (predict_v !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", predict_v); end
    checks++; if (taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", taken); end
    checks++; if (target !== 39'd0) begin failures++; $display("FAIL reset_target got=%h exp=0", target); end
    checks++; if (metadata !== 26'd0) begin failures++; $display("FAIL reset_meta got=%h exp=0", metadata); end
    reset_n = 1;
    model_reset();
    r_v = 1; pc_in = 39'h1000; tick();
    checks++; if (predict_v !== 1'b0 || taken !== 1'b0) begin failures++; $display("FAIL first_lookup pv/taken got=%b%b exp=00", predict_v, taken); end
    checks++; if (metadata[7:0] !== 8'h00) begin failures++; $display("FAIL first_lookup_ghist got=%h exp=00", metadata[7:0]); end
  endtask

  task automatic test_branch();
    set_upd(39'h1000, 2'd0, 1, 39'h2000, 0, mk_meta(6'd0, 9'd0, 3'd0, 8'd0)); tick();
    set_upd(39'h1000, 2'd0, 1, 39'h2000, 0, mk_meta(6'd0, 9'd0, 3'd0, 8'd0)); tick();
    r_v = 1; pc_in = 39'h1000; tick();
    checks++; if (predict_v !== 1'b1 || taken !== 1'b1) begin failures++; $display("FAIL branch_pred pv/taken got=%b%b exp=11", predict_v, taken); end
    checks++; if (target !== 39'h2000) begin failures++; $display("FAIL branch_target got=%h exp=2000", target); end
    tick();
    r_v = 1; pc_in = 39'h1000; tick();
    checks++; if (metadata[7:0] !== 8'h01 || metadata !== e_meta) begin failures++; $display("FAIL branch_ghist got=%h exp=%h", metadata, e_meta); end
  endtask

  task automatic test_call_return();
    set_upd(39'h3000, 2'd2, 1, 39'h4000, 0, mk_meta(6'd0, 9'd0, 3'd0, 8'd0)); tick();
    set_upd(39'h4010, 2'd3, 1, 39'h0, 0, mk_meta(6'd4, 9'd0, 3'd0, 8'd0)); tick();
    r_v = 1; pc_in = 39'h3000; tick();
    checks++; if (predict_v !== 1'b1 || taken !== 1'b1 || target !== 39'h4000) begin failures++; $display("FAIL call_pred got=%b%b %h exp=11 4000", predict_v, taken, target); end
    tick();
    r_v = 1; pc_in = 39'h4010; tick();
    checks++; if (target !== 39'h3004 || predict_v !== 1'b1) begin failures++; $display("FAIL return_target got=%h exp=3004", target); end
    checks++; if (metadata[10:8] !== 3'd1) begin failures++; $display("FAIL return_meta_ptr got=%0d exp=1", metadata[10:8]); end
    tick();
    r_v = 1; pc_in = 39'h1010; tick();
    checks++; if (metadata[10:8] !== 3'd0 || metadata !== e_meta) begin failures++; $display("FAIL ras_ptr_after_ret got=%h exp=%h", metadata, e_meta); end
  endtask

  task automatic test_ras_overflow();
    logic [38:0] rt [9];
    for (int i = 0; i < 9; i++) begin
      set_upd(39'h8040 + 39'(4 * i), 2'd2, 1, 39'h9000 + 39'(i * 256), 0,
              mk_meta(6'(16 + i), 9'd0, 3'd0, 8'd0));
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      r_v = 1; pc_in = 39'h8040 + 39'(4 * i); tick();
      checks++; if (predict_v !== e_pv || target !== e_target) begin failures++; $display("FAIL call_%0d got=%b %h exp=%b %h", i, predict_v, target, e_pv, e_target); end
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      r_v = 1; pc_in = 39'h4010; tick();
      rt[i] = target;
      checks++; if (predict_v !== 1'b1 || target !== e_target) begin failures++; $display("FAIL ret_%0d got=%b %h exp=1 %h", i, predict_v, target, e_target); end
      tick();
    end
    checks++; if (rt[0] !== 39'h8064) begin failures++; $display("FAIL ras_first_ret got=%h exp=8064", rt[0]); end
    checks++; if (rt[1] !== 39'h8060) begin failures++; $display("FAIL ras_second_ret got=%h exp=8060", rt[1]); end
    checks++; if (rt[8] !== 39'h8064) begin failures++; $display("FAIL ras_wrap_ret got=%h exp=8064", rt[8]); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_upd(39'h1020, 2'd0, 1, 39'h5000, 0, mk_meta(6'd8, 9'h00E, 3'd0, 8'h00)); tick();
    end
    set_upd(39'h1020, 2'd0, 0, 39'h5000, 1, mk_meta(6'd8, 9'h00E, 3'd0, 8'h03)); tick();
    r_v = 1; pc_in = 39'h1020; tick();
    checks++; if (predict_v !== 1'b1 || taken !== 1'b1) begin failures++; $display("FAIL sat_taken got=%b%b exp=11", predict_v, taken); end
    checks++; if (metadata[7:0] !== 8'h06 || metadata[19:11] !== 9'h00E) begin failures++; $display("FAIL sat_meta got=%h exp=%h", metadata, e_meta); end
  endtask

  task automatic test_mispredict();
    r_v = 1; pc_in = 39'h1020;
    set_upd(39'h1020, 2'd0, 0, 39'h5000, 1, mk_meta(6'd8, 9'h1F0, 3'd0, 8'h0A));
    tick();
    checks++; if (predict_v !== 1'b0 || taken !== 1'b0) begin failures++; $display("FAIL squash got=%b%b exp=00", predict_v, taken); end
    tick();
    r_v = 1; pc_in = 39'h1020; tick();
    checks++; if (metadata[7:0] !== 8'h14) begin failures++; $display("FAIL restore_ghist got=%h exp=14", metadata[7:0]); end
  endtask

  task automatic test_random();
    logic [38:0] p;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        r_v = 1;
        pc_in = 39'h20000 + 39'($urandom_range(0, 3) * 256) + 39'($urandom_range(0, 3) * 4);
      end
      if ($urandom_range(0, 9) < 4) begin
        p = 39'h20000 + 39'($urandom_range(0, 3) * 256) + 39'($urandom_range(0, 3) * 4);
        set_upd(p, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                {7'($urandom), $urandom}, ($urandom_range(0, 3) == 0),
                mk_meta(p[7:2], 9'($urandom), 3'($urandom), 8'($urandom)));
      end
      tick();
      checks++; if (predict_v !== e_pv) begin failures++; $display("FAIL rnd_pv cyc=%0d got=%b exp=%b", n, predict_v, e_pv); end
      if (e_pv) begin
        checks++; if (taken !== e_taken || target !== e_target) begin failures++; $display("FAIL rnd_pred cyc=%0d got=%b %h exp=%b %h", n, taken, target, e_taken, e_target); end
      end
      if (e_rv) begin
        checks++; if (metadata !== e_meta) begin failures++; $display("FAIL rnd_meta cyc=%0d got=%h exp=%h", n, metadata, e_meta); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    set_upd(39'h1020, 2'd1, 1, 39'h7000, 0, mk_meta(6'd8, 9'd0, 3'd0, 8'd0)); tick();
    r_v = 1; pc_in = 39'h1020; tick();
    checks++; if (predict_v !== 1'b1 || target !== 39'h7000) begin failures++; $display("FAIL pre_reset_jump got=%b %h exp=1 7000", predict_v, target); end
    #3 reset_n = 0;
    #1;
    checks++; if (predict_v !== 1'b0 || taken !== 1'b0 || target !== 39'd0 || metadata !== 26'd0) begin failures++; $display("FAIL async_reset got=%b%b %h %h exp=zeros", predict_v, taken, target, metadata); end
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
    r_v = 1; pc_in = 39'h1020; tick();
    checks++; if (predict_v !== 1'b0 || metadata !== e_meta) begin failures++; $display("FAIL post_reset got=%b %h exp=0 %h", predict_v, metadata, e_meta); end
    tick();
    checks++; if (predict_v !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", predict_v); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branch();
    test_call_return();
    test_ras_overflow();
    test_saturation();
    test_mispredict();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
